// File: rtl/psl_mmio_pkg.sv
// Shared definitions for the PSL MMIO master.
//   mmio_state_t    : FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   TIMEOUT_DEFAULT : default number of WAIT cycles before a missing ack times out
//   ADDR_W / DATA_W : MMIO address and data widths
//   HALF_W          : width of one 32-bit word inside the doubleword data bus
//   WCNT_W          : width of the wait counter
package psl_mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mmio_state_t;

    localparam int TIMEOUT_DEFAULT = 256;
    localparam int ADDR_W          = 24;
    localparam int DATA_W          = 64;
    localparam int HALF_W          = DATA_W / 2;
    localparam int WCNT_W          = 16;

endpackage

// File: rtl/psl_mmio_master_parity_odd.sv
// Odd-parity generator.
//   data : input vector, big-endian [0:W-1]
//   par  : bit that makes the total number of ones in {data, par} odd
// The same block serves as a checker: a received parity bit is good when it
// equals par.
module parity_odd #(
    parameter int W = 8
) (
    input  logic [0:W-1] data,
    output logic         par
);

    assign par = ~(^data);

endmodule

// File: rtl/psl_mmio_master.sv
// PSL MMIO master: turns one request at a time into an MMIO strobe towards
// the AFU and returns exactly one response per accepted request.
//
// Ports (all vectors big-endian [0:N]):
//   ha_pclock, reset        : clock and synchronous active-high reset
//   req_valid/req_ready     : request handshake
//   req_rnw, req_dw, req_cfg: read/write, doubleword/word, descriptor space
//   req_addr, req_wdata     : word address and write data (word: bits 32..63)
//   rsp_valid               : one-cycle response strobe
//   rsp_rdata               : read data (0 for writes, timeouts, align errors)
//   rsp_timeout             : no ack within TIMEOUT_CYCLES WAIT cycles
//   rsp_parerr              : read data parity mismatch
//   rsp_alignerr            : doubleword request to an odd word address
//   ha_mm*                  : MMIO strobe, qualifiers, address, data, parities
//   ah_mmack, ah_mmdata,
//   ah_mmdatapar            : AFU completion and read data
//   dbg_state               : current FSM state
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE, so at most one request is
// outstanding and the requester must hold its fields while req_valid is 1 and
// req_ready is 0. There is no back-pressure on the response: rsp_valid is a
// single-cycle strobe that the requester must take when it appears.
module psl_mmio_master
    import psl_mmio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              ha_pclock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rnw,
    input  logic              req_dw,
    input  logic              req_cfg,
    input  logic [0:ADDR_W-1] req_addr,
    input  logic [0:DATA_W-1] req_wdata,
    output logic              rsp_valid,
    output logic [0:DATA_W-1] rsp_rdata,
    output logic              rsp_timeout,
    output logic              rsp_parerr,
    output logic              rsp_alignerr,
    output logic              ha_mmval,
    output logic              ha_mmcfg,
    output logic              ha_mmrnw,
    output logic              ha_mmdw,
    output logic [0:ADDR_W-1] ha_mmad,
    output logic              ha_mmadpar,
    output logic [0:DATA_W-1] ha_mmdata,
    output logic              ha_mmdatapar,
    input  logic              ah_mmack,
    input  logic [0:DATA_W-1] ah_mmdata,
    input  logic              ah_mmdatapar,
    output mmio_state_t       dbg_state
);

    // Last WAIT cycle index; reaching it without ack ends the wait.
    localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    mmio_state_t       state_q;
    mmio_state_t       state_d;
    logic [WCNT_W-1:0] wait_cnt_q;

    logic              accept;
    logic              align_bad;
    logic              ack_take;
    logic              tmo_hit;

    logic [0:DATA_W-1] issue_data;
    logic [0:DATA_W-1] rd_data;
    logic              rd_par;

    logic [0:DATA_W-1] rsp_rdata_q;
    logic              rsp_timeout_q;
    logic              rsp_parerr_q;
    logic              rsp_alignerr_q;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge ha_pclock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and transition events
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        align_bad = 1'b0;
        ack_take  = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    // Odd word address cannot hold a doubleword: answer
                    // locally without touching the AFU.
                    if (req_dw && req_addr[ADDR_W-1]) begin
                        align_bad = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // The strobe cycle itself; an ack here is too early to be real.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Ack has priority over the timeout in the final WAIT cycle.
                if (ah_mmack) begin
                    ack_take = 1'b1;
                    state_d  = ST_RESP;
                end else if (wait_cnt_q == TMO_LAST) begin
                    tmo_hit  = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outgoing data: reads carry zero, word writes replicate the low word
    // ------------------------------------------------------------------
    always_comb begin
        issue_data = '0;
        if (!req_rnw) begin
            if (req_dw) begin
                issue_data = req_wdata;
            end else begin
                issue_data = {req_wdata[HALF_W:DATA_W-1], req_wdata[HALF_W:DATA_W-1]};
            end
        end
    end

    // Incoming data: word reads return only the low word, zero-extended.
    always_comb begin
        rd_data = ah_mmdata;
        if (!ha_mmdw) begin
            rd_data = {{HALF_W{1'b0}}, ah_mmdata[HALF_W:DATA_W-1]};
        end
    end

    // ------------------------------------------------------------------
    // Parity on address, outgoing data and returned data
    // ------------------------------------------------------------------
    parity_odd #(.W(ADDR_W)) u_ad_par (
        .data (ha_mmad),
        .par  (ha_mmadpar)
    );

    parity_odd #(.W(DATA_W)) u_wd_par (
        .data (ha_mmdata),
        .par  (ha_mmdatapar)
    );

    parity_odd #(.W(DATA_W)) u_rd_par (
        .data (ah_mmdata),
        .par  (rd_par)
    );

    // ------------------------------------------------------------------
    // MMIO command registers: loaded only when a real access is issued and
    // held until the next one, which keeps them stable through RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge ha_pclock) begin
        if (reset) begin
            ha_mmcfg  <= 1'b0;
            ha_mmrnw  <= 1'b0;
            ha_mmdw   <= 1'b0;
            ha_mmad   <= '0;
            ha_mmdata <= '0;
        end else if (accept && !align_bad) begin
            ha_mmcfg  <= req_cfg;
            ha_mmrnw  <= req_rnw;
            ha_mmdw   <= req_dw;
            ha_mmad   <= req_addr;
            ha_mmdata <= issue_data;
        end
    end

    // ------------------------------------------------------------------
    // Wait counter: cleared on the way into WAIT, counts WAIT cycles
    // ------------------------------------------------------------------
    always_ff @(posedge ha_pclock) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q + {{(WCNT_W-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Response registers: set only on the edge into RESP and cleared on
    // every other edge, so they are zero whenever rsp_valid is low.
    // ------------------------------------------------------------------
    always_ff @(posedge ha_pclock) begin
        if (reset) begin
            rsp_rdata_q    <= '0;
            rsp_timeout_q  <= 1'b0;
            rsp_parerr_q   <= 1'b0;
            rsp_alignerr_q <= 1'b0;
        end else begin
            rsp_rdata_q    <= '0;
            rsp_timeout_q  <= 1'b0;
            rsp_parerr_q   <= 1'b0;
            rsp_alignerr_q <= 1'b0;
            if (align_bad) begin
                rsp_alignerr_q <= 1'b1;
            end
            if (ack_take && ha_mmrnw) begin
                rsp_rdata_q  <= rd_data;
                rsp_parerr_q <= (ah_mmdatapar != rd_par);
            end
            if (tmo_hit) begin
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready    = (state_q == ST_IDLE);
    assign ha_mmval     = (state_q == ST_ISSUE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign rsp_parerr   = rsp_parerr_q;
    assign rsp_alignerr = rsp_alignerr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_psl_mmio_master.sv
// Self-checking bench for psl_mmio_master (TIMEOUT_CYCLES = 8).
// Directed scenarios followed by randomized transactions; expected values
// come from a transaction-level model of request, ack timing and data rules.
module tb_psl_mmio_master;
    import psl_mmio_pkg::*;

    localparam int TMO = 8;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        req_valid;
    logic        req_ready;
    logic        req_rnw;
    logic        req_dw;
    logic        req_cfg;
    logic [0:23] req_addr;
    logic [0:63] req_wdata;
    logic        rsp_valid;
    logic [0:63] rsp_rdata;
    logic        rsp_timeout;
    logic        rsp_parerr;
    logic        rsp_alignerr;
    logic        ha_mmval;
    logic        ha_mmcfg;
    logic        ha_mmrnw;
    logic        ha_mmdw;
    logic [0:23] ha_mmad;
    logic        ha_mmadpar;
    logic [0:63] ha_mmdata;
    logic        ha_mmdatapar;
    logic        ah_mmack;
    logic [0:63] ah_mmdata;
    logic        ah_mmdatapar;
    mmio_state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    psl_mmio_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .ha_pclock    (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rnw      (req_rnw),
        .req_dw       (req_dw),
        .req_cfg      (req_cfg),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_timeout  (rsp_timeout),
        .rsp_parerr   (rsp_parerr),
        .rsp_alignerr (rsp_alignerr),
        .ha_mmval     (ha_mmval),
        .ha_mmcfg     (ha_mmcfg),
        .ha_mmrnw     (ha_mmrnw),
        .ha_mmdw      (ha_mmdw),
        .ha_mmad      (ha_mmad),
        .ha_mmadpar   (ha_mmadpar),
        .ha_mmdata    (ha_mmdata),
        .ha_mmdatapar (ha_mmdatapar),
        .ah_mmack     (ah_mmack),
        .ah_mmdata    (ah_mmdata),
        .ah_mmdatapar (ah_mmdatapar),
        .dbg_state    (dbg_state)
    );

    // ------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Odd parity bit over a vector: total ones including the bit is odd.
    function automatic logic odd_par64(input logic [63:0] v);
        int ones = 0;
        for (int b = 0; b < 64; b++) ones += int'(v[b]);
        return (ones % 2 == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk1({pfx, "_req_ready"}, req_ready, 1'b1);
        chk1({pfx, "_state_idle"}, dbg_state == ST_IDLE, 1'b1);
        chk1({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
        chk64({pfx, "_rsp_rdata"}, rsp_rdata, 64'h0);
        chk1({pfx, "_rsp_flags"}, rsp_timeout | rsp_parerr | rsp_alignerr, 1'b0);
        chk1({pfx, "_mmval"}, ha_mmval, 1'b0);
        chk1({pfx, "_mmqual"}, ha_mmcfg | ha_mmrnw | ha_mmdw, 1'b0);
        chk64({pfx, "_mmad"}, 64'(ha_mmad), 64'h0);
        chk1({pfx, "_mmadpar"}, ha_mmadpar, 1'b1);
        chk64({pfx, "_mmdata"}, ha_mmdata, 64'h0);
        chk1({pfx, "_mmdatapar"}, ha_mmdatapar, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // One complete transaction with its expected outcome.
    // ack_at: cycles after the ha_mmval cycle at which ah_mmack pulses
    //   0          -> during the strobe cycle (must be ignored -> timeout)
    //   1..TMO     -> real completion
    //   TMO+1      -> during the timeout response cycle (must be ignored)
    // ------------------------------------------------------------------
    task automatic run_txn(input logic rnw, input logic dw, input logic cfg,
                           input logic [0:23] addr, input logic [0:63] wdata,
                           input int ack_at, input logic [0:63] ack_data,
                           input logic par_ok);
        logic [0:63] exp_mm;
        logic [0:63] exp_rd;
        logic        exp_perr;
        logic        timed_out;
        logic        addr_ones;
        int          resp_at;

        chk1("accept_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_rnw   = rnw;
        req_dw    = dw;
        req_cfg   = cfg;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        // Scramble request fields so only registered copies can be observed.
        req_valid = 1'b0;
        req_rnw   = ~rnw;
        req_dw    = ~dw;
        req_cfg   = ~cfg;
        req_addr  = ~addr;
        req_wdata = {$urandom, $urandom};

        if (dw && addr[23]) begin
            chk1("align_valid", rsp_valid, 1'b1);
            chk1("align_err", rsp_alignerr, 1'b1);
            chk1("align_flags", rsp_timeout | rsp_parerr, 1'b0);
            chk64("align_rdata", rsp_rdata, 64'h0);
            chk1("align_mmval", ha_mmval, 1'b0);
            step();
            chk1("align_done", rsp_valid | rsp_alignerr, 1'b0);
            chk1("align_mmval2", ha_mmval, 1'b0);
            chk1("align_ready", req_ready, 1'b1);
            return;
        end

        exp_mm    = rnw ? 64'h0 : (dw ? wdata : {wdata[32:63], wdata[32:63]});
        timed_out = !(ack_at >= 1 && ack_at <= TMO);
        resp_at   = timed_out ? TMO + 1 : ack_at + 1;
        exp_rd    = (timed_out || !rnw) ? 64'h0
                  : (dw ? ack_data : {32'h0, ack_data[32:63]});
        exp_perr  = rnw && !timed_out && !par_ok;
        addr_ones = ^addr;

        chk1("mmval_on", ha_mmval, 1'b1);
        chk1("req_ready_busy", req_ready, 1'b0);
        chk1("mmcfg", ha_mmcfg, cfg);
        chk1("mmrnw", ha_mmrnw, rnw);
        chk1("mmdw", ha_mmdw, dw);
        chk64("mmad", 64'(ha_mmad), 64'(addr));
        chk1("mmadpar", ha_mmadpar, ~addr_ones);
        chk64("mmdata", ha_mmdata, exp_mm);
        chk1("mmdatapar", ha_mmdatapar, odd_par64(exp_mm));
        chk1("rsp_early", rsp_valid, 1'b0);
        if (ack_at == 0) begin
            ah_mmack     = 1'b1;
            ah_mmdata    = ack_data;
            ah_mmdatapar = odd_par64(ack_data);
        end

        for (int i = 1; i <= resp_at; i++) begin
            step();
            ah_mmack     = 1'b0;
            ah_mmdata    = {$urandom, $urandom};
            ah_mmdatapar = 1'($urandom_range(0, 1));
            chk1("rsp_valid_timing", rsp_valid, (i == resp_at));
            chk1("mmval_single", ha_mmval, 1'b0);
            chk64("mmdata_hold", ha_mmdata, exp_mm);
            chk64("mmad_hold", 64'(ha_mmad), 64'(addr));
            chk1("mmrnw_hold", ha_mmrnw, rnw);
            if (i == resp_at) begin
                chk64("rsp_rdata", rsp_rdata, exp_rd);
                chk1("rsp_timeout", rsp_timeout, timed_out);
                chk1("rsp_parerr", rsp_parerr, exp_perr);
                chk1("rsp_alignerr", rsp_alignerr, 1'b0);
            end else begin
                chk1("rsp_flags_quiet", rsp_timeout | rsp_parerr | rsp_alignerr, 1'b0);
            end
            if (i == ack_at) begin
                ah_mmack     = 1'b1;
                ah_mmdata    = ack_data;
                ah_mmdatapar = par_ok ? odd_par64(ack_data) : ~odd_par64(ack_data);
            end
        end

        step();
        ah_mmack = 1'b0;
        chk1("rsp_one_cycle", rsp_valid, 1'b0);
        chk1("rsp_flags_clear", rsp_timeout | rsp_parerr | rsp_alignerr, 1'b0);
        chk1("back_idle", req_ready, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic        r_rnw;
        logic        r_dw;
        logic        r_cfg;
        logic        r_par;
        logic [0:23] r_addr;
        logic [0:63] r_wdata;
        logic [0:63] r_ack;
        int          r_at;

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_rnw      = 1'b0;
        req_dw       = 1'b0;
        req_cfg      = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        ah_mmack     = 1'b0;
        ah_mmdata    = '0;
        ah_mmdatapar = 1'b0;

        step();
        step();
        chk_reset_vals("por");
        reset = 1'b0;
        step();
        chk1("ready_after_reset", req_ready, 1'b1);

        // Ack outside WAIT while idle: nothing moves.
        ah_mmack = 1'b1;
        step();
        ah_mmack = 1'b0;
        chk1("idle_ack_rsp", rsp_valid, 1'b0);
        chk1("idle_ack_ready", req_ready, 1'b1);
        chk1("idle_ack_mmval", ha_mmval, 1'b0);

        // Doubleword read, ack three cycles after the strobe.
        run_txn(1'b1, 1'b1, 1'b0, 24'h000010, 64'h0, 3, 64'h0123456789ABCDEF, 1'b1);
        // Word write, low word replicated on both halves.
        run_txn(1'b0, 1'b0, 1'b0, 24'h000005, 64'h0000_0000_DEAD_BEEF, 2,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        // Doubleword read to odd word address.
        run_txn(1'b1, 1'b1, 1'b0, 24'h000003, 64'h0, 1, 64'h0, 1'b1);
        // No ack at all: timeout after TMO WAIT cycles.
        run_txn(1'b1, 1'b1, 1'b0, 24'h000020, 64'h0, TMO + 5, 64'h0, 1'b1);
        step();
        step();
        ah_mmack  = 1'b1;
        ah_mmdata = 64'hAAAA_5555_AAAA_5555;
        step();
        ah_mmack = 1'b0;
        chk1("late_ack_rsp", rsp_valid, 1'b0);
        chk1("late_ack_ready", req_ready, 1'b1);
        chk1("late_ack_mmval", ha_mmval, 1'b0);
        step();
        chk1("late_ack_rsp2", rsp_valid, 1'b0);
        // Ack in the last WAIT cycle beats the timeout.
        run_txn(1'b1, 1'b0, 1'b1, 24'h000101, 64'h0, TMO, 64'h1122_3344_5566_7788, 1'b1);
        // Ack during the strobe cycle is ignored -> timeout.
        run_txn(1'b0, 1'b1, 1'b0, 24'h000200, 64'hCAFE_F00D_1234_5678, 0, 64'h0, 1'b1);
        // Ack during the timeout response cycle is ignored.
        run_txn(1'b1, 1'b0, 1'b0, 24'h000031, 64'h0, TMO + 1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
        // Bad read parity.
        run_txn(1'b1, 1'b1, 1'b0, 24'h000040, 64'h0, 2, 64'h8000_0000_0000_0001, 1'b0);
        // Bad parity on a write completion does not matter.
        run_txn(1'b0, 1'b1, 1'b0, 24'h000042, 64'h1357_9BDF_2468_ACE0, 1,
                64'hFFFF_0000_FFFF_0000, 1'b0);

        // Reset one cycle after the strobe aborts the transaction.
        req_valid = 1'b1;
        req_rnw   = 1'b1;
        req_dw    = 1'b1;
        req_cfg   = 1'b1;
        req_addr  = 24'h000100;
        step();
        req_valid = 1'b0;
        chk1("abort_mmval", ha_mmval, 1'b1);
        step();
        reset = 1'b1;
        chk1("abort_no_rsp", rsp_valid, 1'b0);
        step();
        reset = 1'b0;
        chk_reset_vals("abort");
        ah_mmack     = 1'b1;
        ah_mmdata    = 64'h0123456789ABCDEF;
        ah_mmdatapar = 1'b1;
        step();
        ah_mmack = 1'b0;
        chk1("abort_ack_rsp", rsp_valid, 1'b0);
        chk1("abort_ack_ready", req_ready, 1'b1);
        chk1("abort_ack_mmval", ha_mmval, 1'b0);
        step();
        chk1("abort_ack_rsp2", rsp_valid, 1'b0);

        // Randomized transactions.
        for (int k = 0; k < 24; k++) begin
            r_rnw   = 1'($urandom_range(0, 1));
            r_dw    = 1'($urandom_range(0, 1));
            r_cfg   = 1'($urandom_range(0, 1));
            r_par   = ($urandom_range(0, 3) != 0);
            r_addr  = 24'($urandom_range(0, 32'h00FF_FFFF));
            r_wdata = {$urandom, $urandom};
            r_ack   = {$urandom, $urandom};
            r_at    = int'($urandom_range(0, TMO + 1));
            run_txn(r_rnw, r_dw, r_cfg, r_addr, r_wdata, r_at, r_ack, r_par);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
